slice_share_sched: RTL and testbench

- Time-multiplexes one shared 12-bit `submodule1` slice datapath between NUM_REQ requesters.
- Each requester presents a 12-bit A/B operand pair.
  - The scheduler grants requesters round-robin.
  - It drives the captured operands onto the shared slice.
  - It registers the slice's C result and returns it to the granted requester with a one-cycle valid pulse.
- Sits between the lane logic and a single `submodule1` instance. This replaces the per-lane U1/U2/U3 replication when area matters more than throughput.

---
 rtl/slice_share_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/slice_share_sched.sv | 116 +++++++++++
 tb/tb_slice_share_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_share_pkg.sv
// Shared types and default sizing for the time-multiplexed slice scheduler.
// Scheduler sequencing states plus the default requester count and slice width.
package slice_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam int DEFAULT_NUM_REQ = 3;
    localparam int DEFAULT_SLICE_W = 12;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request searching upward from rr_ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is honoured.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    always_comb begin
        logic [IDX_W:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr + k stays below 2*NUM_REQ, so one conditional subtract wraps it.
            idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_REQ)) begin
                idx = idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!any && req[idx[IDX_W-1:0]]) begin
                any                   = 1'b1;
                gnt[idx[IDX_W-1:0]]   = 1'b1;
                gnt_idx               = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/slice_share_sched.sv
// Shares one slice datapath among NUM_REQ requesters, granted round-robin.
// Latency: accept at t, registered result with rsp_valid pulse at t+2, next accept at t+3.
// Backpressure: req_ready only in IDLE; no response backpressure (one-cycle rsp_valid pulse).
module slice_share_sched
    import slice_share_pkg::*;
#(
    parameter int  NUM_REQ = DEFAULT_NUM_REQ,
    parameter int  SLICE_W = DEFAULT_SLICE_W,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*SLICE_W-1:0] req_a,
    input  logic [NUM_REQ*SLICE_W-1:0] req_b,
    output logic [SLICE_W-1:0]         slice_a,
    output logic [SLICE_W-1:0]         slice_b,
    input  logic [SLICE_W-1:0]         slice_c,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [SLICE_W-1:0]         rsp_data,
    output logic                       busy
);

    state_e               state;
    state_e               state_nxt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic [SLICE_W-1:0]   op_a;
    logic [SLICE_W-1:0]   op_b;
    logic [SLICE_W-1:0]   rsp_data_q;
    logic                 accept;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                // Never advertise ready while reset is being applied.
                req_ready = arb_gnt & {NUM_REQ{~rst}};
                accept    = arb_any;
                if (arb_any) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                busy = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    rsp_valid[i] = (gnt_idx == IDX_W'(i));
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            gnt_idx    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                op_a    <= req_a[int'(arb_idx)*SLICE_W +: SLICE_W];
                op_b    <= req_b[int'(arb_idx)*SLICE_W +: SLICE_W];
                gnt_idx <= arb_idx;
            end
            if (state == ISSUE) begin
                rsp_data_q <= slice_c;
            end
            // Explicit compare keeps the wrap correct for non-power-of-two NUM_REQ.
            if (state == RESP) begin
                rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    assign slice_a  = op_a;
    assign slice_b  = op_b;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_slice_share_sched.sv
// Bench for slice_share_sched with an XOR stub slice: vector table, directed corners,
// and randomized traffic against a transaction-level reference model.
module tb_slice_share_sched;

    localparam int N = 3;
    localparam int W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [W-1:0]     slice_a;
    logic [W-1:0]     slice_b;
    logic [W-1:0]     slice_c;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_data;
    logic             busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign slice_c = slice_a ^ slice_b;

    slice_share_sched #(.NUM_REQ(N), .SLICE_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_c   (slice_c),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    // reference model state
    int           ptr;
    int           free_at;
    int           idx;
    int           pend_due;
    int           pend_idx;
    bit           pend;
    logic [W-1:0] pend_data;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rsp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        vecs[0] = '{valid: 3'b001, a: 12'h123, b: 12'h456, exp_ready: 3'b001, exp_data: 12'h575};
        vecs[1] = '{valid: 3'b110, a: 12'h0F0, b: 12'h00F, exp_ready: 3'b010, exp_data: 12'h0FE};
        vecs[2] = '{valid: 3'b100, a: 12'hFFF, b: 12'hFFF, exp_ready: 3'b100, exp_data: 12'hFFE};
        vecs[3] = '{valid: 3'b111, a: 12'h800, b: 12'h001, exp_ready: 3'b001, exp_data: 12'h801};
        vecs[4] = '{valid: 3'b000, a: 12'h333, b: 12'h333, exp_ready: 3'b000, exp_data: 12'h000};
        vecs[5] = '{valid: 3'b101, a: 12'hA5A, b: 12'h5A5, exp_ready: 3'b001, exp_data: 12'hFFF};

        // reset then idle
        do_reset();
        for (int c = 0; c < 10; c++) begin
            sample();
            chk("idle_ready", 32'(req_ready), 32'd0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_slice_a", 32'(slice_a), 32'd0);
            chk("idle_slice_b", 32'(slice_b), 32'd0);
            step();
        end

        // vector table, each from the post-reset pointer; requester i gets A = a + i
        foreach (vecs[v]) begin
            do_reset();
            for (int i = 0; i < N; i++) set_ops(i, vecs[v].a + W'(i), vecs[v].b);
            req_valid = vecs[v].valid;
            sample();
            chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            step();
            req_valid = '0;
            sample();
            chk($sformatf("vec%0d_early_rsp", v), 32'(rsp_valid), 32'd0);
            step();
            sample();
            chk($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'(vecs[v].exp_ready));
            if (vecs[v].exp_ready != '0)
                chk($sformatf("vec%0d_rsp_data", v), 32'(rsp_data), 32'(vecs[v].exp_data));
            step();
        end

        // single request from requester 1
        do_reset();
        set_ops(1, 12'hA5A, 12'h0F0);
        req_valid = 3'b010;
        sample();
        chk("single_ready", 32'(req_ready), 32'b010);
        chk("single_busy_t", 32'(busy), 32'd0);
        step();
        req_valid = '0;
        sample();
        chk("single_busy_t1", 32'(busy), 32'd1);
        chk("single_slice_a", 32'(slice_a), 32'hA5A);
        chk("single_ready_t1", 32'(req_ready), 32'd0);
        step();
        sample();
        chk("single_busy_t2", 32'(busy), 32'd1);
        chk("single_rsp_valid", 32'(rsp_valid), 32'b010);
        chk("single_rsp_data", 32'(rsp_data), 32'hAAA);
        step();
        sample();
        chk("single_busy_t3", 32'(busy), 32'd0);
        chk("single_rsp_off", 32'(rsp_valid), 32'd0);
        step();

        // all requesters continuously valid: grants rotate 0,1,2,0 every 3 cycles
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, W'(i), 12'h100);
        req_valid = 3'b111;
        for (int g = 0; g < 4; g++) begin
            sample();
            chk($sformatf("rot%0d_ready", g), 32'(req_ready), 32'(1 << (g % N)));
            step();
            sample();
            chk($sformatf("rot%0d_ready_issue", g), 32'(req_ready), 32'd0);
            step();
            sample();
            chk($sformatf("rot%0d_rsp_valid", g), 32'(rsp_valid), 32'(1 << (g % N)));
            chk($sformatf("rot%0d_rsp_data", g), 32'(rsp_data), 32'(12'h100 ^ W'(g % N)));
            step();
        end
        req_valid = '0;

        // operands captured at accept
        do_reset();
        set_ops(0, 12'h001, 12'h000);
        req_valid = 3'b001;
        sample();
        chk("capture_ready", 32'(req_ready), 32'b001);
        step();
        req_valid = '0;
        set_ops(0, 12'hFFF, 12'h000);
        step();
        sample();
        chk("capture_rsp_valid", 32'(rsp_valid), 32'b001);
        chk("capture_rsp_data", 32'(rsp_data), 32'h001);
        step();

        // reset mid-operation abandons the transaction
        do_reset();
        set_ops(2, 12'h222, 12'h111);
        req_valid = 3'b100;
        sample();
        chk("abort_ready", 32'(req_ready), 32'b100);
        step();
        req_valid = '0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sample();
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
            chk("abort_not_busy", 32'(busy), 32'd0);
            step();
        end
        req_valid = 3'b111;
        sample();
        chk("abort_next_grant", 32'(req_ready), 32'b001);
        step();
        req_valid = '0;
        step();
        step();

        // pointer wrap after granting the last requester
        do_reset();
        set_ops(0, 12'h00A, 12'h000);
        set_ops(2, 12'h00C, 12'h000);
        req_valid = 3'b100;
        sample();
        chk("wrap_first", 32'(req_ready), 32'b100);
        step();
        req_valid = '0;
        step();
        step();
        req_valid = 3'b101;
        sample();
        chk("wrap_to_0", 32'(req_ready), 32'b001);
        step();
        step();
        sample();
        chk("wrap_rsp0", 32'(rsp_data), 32'h00A);
        step();
        sample();
        chk("wrap_then_2", 32'(req_ready), 32'b100);
        step();
        req_valid = '0;
        step();
        step();

        // randomized traffic with occasional resets against the transaction model
        do_reset();
        ptr     = 0;
        free_at = 0;
        pend    = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = N'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom));
            sample();
            exp_ready = '0;
            idx       = -1;
            if (!rst && c >= free_at) begin
                for (int k = 0; k < N; k++) begin
                    if (idx < 0 && req_valid[(ptr + k) % N]) idx = (ptr + k) % N;
                end
            end
            if (idx >= 0) exp_ready[idx] = 1'b1;
            exp_rsp = (pend && pend_due == c) ? N'(1 << pend_idx) : '0;
            chk("rand_ready", 32'(req_ready), 32'(exp_ready));
            chk("rand_rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            if (exp_rsp != '0) chk("rand_rsp_data", 32'(rsp_data), 32'(pend_data));
            chk("rand_busy", 32'(busy), (c < free_at) ? 32'd1 : 32'd0);
            if (rst) begin
                pend    = 1'b0;
                ptr     = 0;
                free_at = c + 1;
            end else if (idx >= 0) begin
                pend      = 1'b1;
                pend_due  = c + 2;
                pend_idx  = idx;
                pend_data = req_a[idx*W +: W] ^ req_b[idx*W +: W];
                free_at   = c + 3;
                ptr       = (idx + 1) % N;
            end
            step();
        end
        rst       = 1'b0;
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
